// File: rtl/mux_scan_serializer_pkg.sv
// Shared constants, state encoding and scan-order select bounds for the
// mux scan serializer.
package mux_scan_serializer_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] SEL_START_MSB = 4'd15;
    localparam logic [SEL_W-1:0] SEL_END_MSB   = 4'd0;
    localparam logic [SEL_W-1:0] SEL_START_LSB = 4'd0;
    localparam logic [SEL_W-1:0] SEL_END_LSB   = 4'd15;

endpackage

// File: rtl/mux_16_1.sv
// 16:1 multiplexer built as a four-level tree of 2:1 muxes; sel[0] picks
// between adjacent leaves, sel[3] makes the final choice.
module mux_16_1 (
    input  logic [15:0] d,
    input  logic [3:0]  sel,
    output logic        y
);

    logic [7:0] l1;
    logic [3:0] l2;
    logic [1:0] l3;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_l1
            assign l1[i] = sel[0] ? d[2*i+1] : d[2*i];
        end
        for (i = 0; i < 4; i++) begin : g_l2
            assign l2[i] = sel[1] ? l1[2*i+1] : l1[2*i];
        end
        for (i = 0; i < 2; i++) begin : g_l3
            assign l3[i] = sel[2] ? l2[2*i+1] : l2[2*i];
        end
    endgenerate

    assign y = sel[3] ? l3[1] : l3[0];

endmodule

// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial stage: holds a 16-bit word and walks the mux_16_1
// select lines, emitting one bit per valid/ready transfer.
// Define SCAN_PARITY_EN to append an even-parity bit after the data bits.
module mux_scan_serializer
    import mux_scan_serializer_pkg::*;
#(
    parameter int DATA_W_P  = DATA_W,
    parameter int SEL_W_P   = SEL_W,
    parameter int MSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [DATA_W_P-1:0] load_data,
    output logic                ser_valid,
    input  logic                ser_ready,
    output logic                ser_bit,
    output logic                ser_last,
    output logic [SEL_W_P-1:0]  sel_out,
    output logic                busy
);

    localparam logic [SEL_W_P-1:0] SEL_START = (MSB_FIRST != 0) ? SEL_START_MSB : SEL_START_LSB;
    localparam logic [SEL_W_P-1:0] SEL_END   = (MSB_FIRST != 0) ? SEL_END_MSB   : SEL_END_LSB;

    state_t              state;
    logic [DATA_W_P-1:0] hold;
    logic [SEL_W_P-1:0]  sel;
    logic                mux_y;
    logic                is_last;
    logic                data_bit;

    mux_16_1 u_mux (
        .d   (hold),
        .sel (sel),
        .y   (mux_y)
    );

`ifdef SCAN_PARITY_EN
    // Position 0..15 are data bits, position 16 is the parity slot.
    logic [4:0] pos;
    assign is_last  = (pos == 5'(DATA_W_P));
    assign data_bit = is_last ? ^hold : mux_y;
`else
    assign is_last  = (sel == SEL_END);
    assign data_bit = mux_y;
`endif

    assign ser_bit  = (state == SCAN) & data_bit;
    assign ser_last = (state == SCAN) & is_last;
    assign sel_out  = sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold       <= '0;
            sel        <= SEL_START;
            load_ready <= 1'b1;
            ser_valid  <= 1'b0;
            busy       <= 1'b0;
`ifdef SCAN_PARITY_EN
            pos        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid && load_ready) begin
                        hold       <= load_data;
                        sel        <= SEL_START;
                        state      <= SCAN;
                        load_ready <= 1'b0;
                        ser_valid  <= 1'b1;
                        busy       <= 1'b1;
`ifdef SCAN_PARITY_EN
                        pos        <= '0;
`endif
                    end
                end
                SCAN: begin
                    if (ser_valid && ser_ready) begin
                        if (is_last) begin
                            state      <= IDLE;
                            sel        <= SEL_START;
                            load_ready <= 1'b1;
                            ser_valid  <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
`ifdef SCAN_PARITY_EN
                            pos <= pos + 5'd1;
                            // sel parks on the end value through the parity slot
                            if (sel != SEL_END)
                                sel <= (MSB_FIRST != 0) ? sel - 1'b1 : sel + 1'b1;
`else
                            sel <= (MSB_FIRST != 0) ? sel - 1'b1 : sel + 1'b1;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Scoreboard bench: two serializers (MSB-first and LSB-first) share clock and
// reset; stimulus pushes expected bits, per-DUT monitors pop on each transfer.
module tb_mux_scan_serializer;

`ifdef SCAN_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_load_valid, a_load_ready, a_ser_valid, a_ser_ready, a_ser_bit, a_ser_last, a_busy;
    logic [15:0] a_load_data;
    logic [3:0]  a_sel_out;
    logic        b_load_valid, b_load_ready, b_ser_valid, b_ser_ready, b_ser_bit, b_ser_last, b_busy;
    logic [15:0] b_load_data;
    logic [3:0]  b_sel_out;

    mux_scan_serializer #(.MSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst),
        .load_valid(a_load_valid), .load_ready(a_load_ready), .load_data(a_load_data),
        .ser_valid(a_ser_valid), .ser_ready(a_ser_ready), .ser_bit(a_ser_bit),
        .ser_last(a_ser_last), .sel_out(a_sel_out), .busy(a_busy)
    );

    mux_scan_serializer #(.MSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst),
        .load_valid(b_load_valid), .load_ready(b_load_ready), .load_data(b_load_data),
        .ser_valid(b_ser_valid), .ser_ready(b_ser_ready), .ser_bit(b_ser_bit),
        .ser_last(b_ser_last), .sel_out(b_sel_out), .busy(b_busy)
    );

    typedef struct {
        logic       b;
        logic       l;
        logic [3:0] s;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   errs = 0;
    int   checks = 0;
    int   a_busy_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: select order, mux bit, last flag and optional parity.
    task automatic push_word(input bit msb, input logic [15:0] w);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.s = msb ? 4'(15 - i) : 4'(i);
            e.b = w[e.s];
            e.l = (i == 15) && !PAR;
            if (msb) qa.push_back(e); else qb.push_back(e);
        end
        if (PAR) begin
            e.s = msb ? 4'd0 : 4'd15;
            e.b = ^w;
            e.l = 1'b1;
            if (msb) qa.push_back(e); else qb.push_back(e);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst) begin
            if (a_busy) a_busy_cnt++;
            if (a_ser_valid && a_ser_ready) begin
                if (qa.size() == 0) chk("a_unexpected_bit", 1, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_ser_bit", a_ser_bit, e.b);
                    chk("a_ser_last", a_ser_last, e.l);
                    chk("a_sel_out", a_sel_out, e.s);
                end
            end else if (!a_ser_valid) begin
                chk("a_idle_gate", {a_ser_bit, a_ser_last}, 0);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst) begin
            if (b_ser_valid && b_ser_ready) begin
                if (qb.size() == 0) chk("b_unexpected_bit", 1, 0);
                else begin
                    e = qb.pop_front();
                    chk("b_ser_bit", b_ser_bit, e.b);
                    chk("b_ser_last", b_ser_last, e.l);
                    chk("b_sel_out", b_sel_out, e.s);
                end
            end else if (!b_ser_valid) begin
                chk("b_idle_gate", {b_ser_bit, b_ser_last}, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (!a_load_ready && n < 200) begin tick(); n++; end
        if (n >= 200) chk("a_idle_timeout", 0, 1);
    endtask

    task automatic wait_idle_b();
        int n = 0;
        while (!b_load_ready && n < 200) begin tick(); n++; end
        if (n >= 200) chk("b_idle_timeout", 0, 1);
    endtask

    task automatic wait_sel_a(input logic [3:0] s);
        int n = 0;
        while (!(a_busy && a_sel_out == s) && n < 200) begin tick(); n++; end
        if (n >= 200) chk("a_sel_timeout", 0, 1);
    endtask

    task automatic load_a(input logic [15:0] w);
        wait_idle_a();
        push_word(1'b1, w);
        a_load_valid = 1'b1;
        a_load_data  = w;
        tick();
        a_load_valid = 1'b0;
        chk("a_first_bit_latency", a_ser_valid, 1);
    endtask

    task automatic load_b(input logic [15:0] w);
        wait_idle_b();
        push_word(1'b0, w);
        b_load_valid = 1'b1;
        b_load_data  = w;
        tick();
        b_load_valid = 1'b0;
        chk("b_first_bit_latency", b_ser_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        logic       sb;
        logic [3:0] ss;
        rst = 1'b1;
        a_load_valid = 0; a_load_data = '0; a_ser_ready = 1;
        b_load_valid = 0; b_load_data = '0; b_ser_ready = 1;
        #12;
        chk("rst_a_load_ready", a_load_ready, 1);
        chk("rst_a_ser_valid", a_ser_valid, 0);
        chk("rst_a_ser_bit", a_ser_bit, 0);
        chk("rst_a_ser_last", a_ser_last, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_sel", a_sel_out, 15);
        chk("rst_b_sel", b_sel_out, 0);
        chk("rst_b_load_ready", b_load_ready, 1);
        tick();
        rst = 1'b0;
        tick();

        // MSB-first alternating pattern; load_ready one cycle after last bit
        load_a(16'hAAAA);
        n = 0;
        while (!a_ser_last && n < 100) begin tick(); n++; end
        if (n >= 100) chk("a_last_timeout", 0, 1);
        tick();
        chk("a_ready_after_last", a_load_ready, 1);

        // LSB-first single set bit
        load_b(16'h0001);
        wait_idle_b();

        // Backpressure: 3 stall cycles at sel=12
        wait_idle_a();
        c0 = a_busy_cnt;
        load_a(16'h5555);
        wait_sel_a(4'd12);
        a_ser_ready = 1'b0;
        sb = a_ser_bit;
        ss = a_sel_out;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_ser_bit", a_ser_bit, sb);
            chk("bp_sel_out", a_sel_out, ss);
            chk("bp_ser_valid", a_ser_valid, 1);
        end
        a_ser_ready = 1'b1;
        wait_idle_a();
        chk("bp_scan_cycles", a_busy_cnt - c0, PAR ? 20 : 19);

        // Load attempt while busy must be ignored
        load_a(16'h0000);
        wait_sel_a(4'd10);
        a_load_valid = 1'b1;
        a_load_data  = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("busy_load_ready", a_load_ready, 0);
        end
        a_load_valid = 1'b0;
        wait_idle_a();

        // Reset mid-scan aborts immediately
        load_a(16'hF0F0);
        wait_sel_a(4'd7);
        rst = 1'b1;
        #1;
        chk("mid_rst_ser_valid", a_ser_valid, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_load_ready", a_load_ready, 1);
        chk("mid_rst_sel", a_sel_out, 15);
        qa.delete();
        tick();
        rst = 1'b0;
        tick();
        load_a(16'h8000);
        wait_idle_a();

        // Parity-sensitive word (odd weight) on both scan orders
        load_a(16'h0007);
        load_b(16'hC3A5);
        wait_idle_a();
        wait_idle_b();

        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin tick(); n++; end
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
Parallel-to-serial stage built around the lab's 16:1 gate-level multiplexer. It accepts a 16-bit word over a valid/ready handshake and holds it in a register. It drives the mux select lines through all 16 positions and emits one mux output bit per cycle over a downstream valid/ready serial handshake. It is the sequencing stage that feeds the mux its select lines and consumes its output line.

Parameters:
DATA_W, 16, word width; fixed by mux_16_1; other values unsupported.
SEL_W, 4, select width; log2(DATA_W).
MSB_FIRST, 1, 1 = scan select 15 down to 0; 0 = scan 0 up to 15.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
load_valid  input  1  upstream word available.
load_ready  output  1  block can accept a word.
load_data  input  DATA_W  word to serialize.
ser_valid  output  1  ser_bit is valid.
ser_ready  input  1  downstream accepts ser_bit.
ser_bit  output  1  current mux output bit.
ser_last  output  1  final bit of the current word.
sel_out  output  SEL_W  select lines currently driven into the mux (debug/observe).
busy  output  1  word in flight (state != IDLE).

Behaviour:
- Reset (async assert, synchronous release to clk):
  - state=IDLE; hold register=0; sel=start value (15 if MSB_FIRST, else 0).
  - Outputs: load_ready=1, ser_valid=0, ser_bit=0, ser_last=0, busy=0, sel_out=start value.
- States: IDLE, SCAN.
- IDLE:
  - load_ready=1.
  - On load_valid&&load_ready: capture load_data into the hold register, set sel=start, go to SCAN.
  - Otherwise stay in IDLE.
- SCAN:
  - load_ready=0 and busy=1; load_valid is ignored (no capture, no error).
  - ser_valid=1; ser_bit = mux_16_1(hold, sel) output.
  - ser_last=1 when sel equals the end value (0 if MSB_FIRST, else 15).
- Transfer rule: a bit transfers on a cycle with ser_valid&&ser_ready.
  - Not last: sel steps by 1 (decrement if MSB_FIRST, else increment).
  - Last: go to IDLE.
- Backpressure: while ser_ready=0, sel, ser_bit, ser_last and the hold register stay stable. ser_valid never drops once asserted until the transfer completes.
- Outside SCAN, ser_bit and ser_last are gated to 0.
- Latency: first bit is valid the cycle after load acceptance.
- Throughput: with ser_ready held high, a word takes 16 cycles in SCAN plus 1 IDLE cycle, so 17 cycles/word. No back-to-back load in the last-bit cycle.
- Select counter: SEL_W bits, never wraps. Termination is by the ser_last compare, not by overflow.
- Reset mid-scan: immediate abort to the reset values above. The partial word is discarded and no ser_last is produced.
- Mux usage: the mux_16_1 output is combinational from the hold register and sel, both registered. There is no extra pipeline register on ser_bit.

Optional Feature:
Macro SCAN_PARITY_EN.
- Defined:
  - After the 16 data bits, one extra bit is emitted: even parity, the XOR of all 16 hold bits.
  - ser_last moves to the parity bit; ser_last is 0 on the 16th data bit.
  - An internal 5-bit position counter tracks the parity slot; sel_out holds the end value during the parity bit.
  - Word time becomes 18 cycles with ser_ready high.
- Undefined: exactly 16 bits per word, as specified above.

Decomposition:
- Shared package/include holds: DATA_W=16, SEL_W=4, the state encodings (IDLE, SCAN), and the SEL_START/SEL_END values for both scan orders.
- One sub-module: the existing mux_16_1, instantiated unchanged. The FSM, select counter, hold register and handshake logic live in mux_scan_serializer.

Test Plan:
- MSB_FIRST=1, load 16'hAAAA, ser_ready=1:
  - ser_bit sequence is 1,0,1,0,… (16 bits), sel_out counts 15→0.
  - ser_last high only on cycle 16; load_ready returns 1 one cycle later.
- MSB_FIRST=0, load 16'h0001:
  - ser_bit = 1 on the first bit, then 0 for the remaining 15.
  - ser_last coincides with sel_out=15.
- Backpressure: load 16'h5555, hold ser_ready=0 for 3 cycles at sel=12.
  - ser_bit, sel_out and ser_valid stay constant for those cycles.
  - The word completes with 19 total SCAN cycles.
- Load during busy: assert load_valid with 16'hFFFF mid-scan of 16'h0000.
  - load_ready=0 and the hold register is unchanged; all 16 output bits are 0.
- Reset mid-scan: assert rst at sel=7 of 16'hF0F0.
  - Same cycle (async): ser_valid=0, busy=0, load_ready=1, sel_out=15.
  - After release, a new load of 16'h8000 streams correctly.
- SCAN_PARITY_EN defined, load 16'h0007:
  - 17 bits are emitted; the 17th bit is 1; ser_last is on bit 17 only.
